uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised multi-byte UART transmitter, successor to the fixed 8-byte/9600-baud sender.
- Latches a packed word of up to MAX_BYTES characters plus a per-frame length on a start pulse.
- Serialises the characters back-to-back on tx, with configurable data width, parity and stop bits.
- Reports busy/done handshakes to the upstream packet builder.
- Sits between the command/packet assembly logic and the board USB-UART bridge pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate; BAUD_DIV = CLK_FREQ/BAUD (integer, truncated); BAUD_DIV must be >= 4.
- MAX_BYTES, 8, maximum characters per frame; range 1..16.
- DATA_BITS, 8, data bits per character; range 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per character; 1 or 2.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ip_data, input, MAX_BYTES*DATA_BITS, packed characters; character k is ip_data[k*DATA_BITS +: DATA_BITS].
- ip_len, input, LEN_W = $clog2(MAX_BYTES+1), number of characters to send; sampled with ip_flag.
- ip_flag, input, 1, start request, sampled every clock.
- busy, output, 1, high while a frame is in progress.
- done, output, 1, one-cycle pulse when the frame completes.
- tx, output, 1, serial line; idle high.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, busy=0, done=0, state=IDLE, all counters 0.
  - A reset asserted mid-frame aborts the frame immediately: tx returns to 1 and no done pulse is issued.
- Acceptance:
  - ip_flag=1 with busy=0 and ip_len!=0 is accepted at that edge.
  - ip_data and ip_len are latched into internal registers; later changes on the inputs have no effect.
  - Values of ip_len above MAX_BYTES are clamped to MAX_BYTES.
  - ip_flag with ip_len=0 is ignored: busy stays 0 and done is not pulsed.
  - ip_flag while busy=1 is ignored; requests are not queued.
- Latency: busy=1 and tx=0 (start bit) are visible in the cycle after the accepting edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after 1 bit time.
  - DATA -> PARITY after DATA_BITS bit times when PARITY!=0; DATA -> STOP when PARITY=0.
  - PARITY -> STOP after 1 bit time.
  - STOP -> START when characters remain; STOP -> IDLE after the last character.
  - STOP lasts STOP_BITS bit times.
- Bit timing:
  - Every bit, including start, parity and stop, lasts exactly BAUD_DIV clocks.
  - The baud counter runs 0..BAUD_DIV-1 and wraps.
  - The bit counter and character counter advance only on the wrap cycle.
- Bit and character order:
  - Data is sent LSB first.
  - Characters are sent in order k = 0..len-1.
  - There is no idle gap between characters: the next start bit follows the last stop bit directly.
- Parity bit:
  - Even mode: XOR of the character's data bits.
  - Odd mode: inverted XOR of the character's data bits.
- Line levels: tx is registered and glitch-free; start bit = 0, stop bit(s) = 1.
- Frame length: total frame time = len * (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV clocks.
- Completion:
  - At the edge ending the last stop bit, state->IDLE, busy<=0 and done<=1 for exactly one cycle; tx stays 1.
  - An ip_flag sampled during the done cycle is accepted, so frames can be sent back-to-back with one idle-high clock between them.
- Counter widths:
  - Baud counter is $clog2(BAUD_DIV) bits.
  - Character counter is LEN_W bits.
  - No counter may overflow for any legal parameter set.

Test Plan:
- CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), defaults, ip_len=1, ip_data[7:0]=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 10 clocks; done high at clock 101 after acceptance; busy high for exactly 100 clocks.
- Same setup, ip_len=8, ip_data=64'h0807060504030201 -> characters 01..08 in order, no gaps, 800 clocks total, a single done pulse.
- PARITY=2, STOP_BITS=2, ip_len=2, characters 8'h07 then 8'h03 -> parity bits 1 then 0, each stop period 20 clocks, frame time 240 clocks.
- Ignored and abnormal requests:
  - ip_flag pulsed mid-frame with ip_data changed -> no effect on the transmitted data.
  - ip_len=0 -> busy stays 0 and done is not pulsed.
  - ip_len=12 with MAX_BYTES=8 -> exactly 8 characters are sent.
- Assert rst_n=0 during the DATA state of character 3 -> tx=1 and busy=0 asynchronously, no done pulse; a new request after release sends a clean frame.
- ip_flag held high continuously with ip_len=1 -> consecutive frames separated by exactly one idle clock at tx=1; done pulses once per frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_tx_frame                                                |
// | Purpose : multi-character UART transmitter with configurable framing   |
// | Rev     : 1.0 - initial parametrised release                           |
// +------------------------------------------------------------------------+
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int MAX_BYTES = 8,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [MAX_BYTES*DATA_BITS-1:0] ip_data,
  input  logic [LEN_W-1:0]               ip_len,
  input  logic                           ip_flag,
  output logic                           busy,
  output logic                           done,
  output logic                           tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BCNT_W   = $clog2(BAUD_DIV);
  localparam int BIT_W    = 3;
  localparam int DW       = MAX_BYTES * DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              r_state,    w_state;
  logic [BCNT_W-1:0]   r_baud_cnt, w_baud_cnt;
  logic [BIT_W-1:0]    r_bit_cnt,  w_bit_cnt;
  logic [LEN_W-1:0]    r_char_cnt, w_char_cnt;
  logic [LEN_W-1:0]    r_len,      w_len;
  logic [DW-1:0]       r_data,     w_data;
  logic [DATA_BITS-1:0] r_shift,   w_shift;
  logic                r_tx,       w_tx;
  logic                r_busy,     w_busy;
  logic                r_done,     w_done;

  logic                w_wrap;
  logic                w_par;
  logic [DW-1:0]       w_data_nxt;
  logic [LEN_W-1:0]    w_len_clamp;

  // r_data keeps the current character in its low DATA_BITS; the rest queue behind it
  assign w_wrap      = (r_baud_cnt == BCNT_W'(BAUD_DIV - 1));
  assign w_par       = (^r_data[DATA_BITS-1:0]) ^ (PARITY == 1);
  assign w_data_nxt  = r_data >> DATA_BITS;
  assign w_len_clamp = (ip_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : ip_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_char_cnt <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_baud_cnt <= w_baud_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_char_cnt <= w_char_cnt;
      r_len      <= w_len;
      r_data     <= w_data;
      r_shift    <= w_shift;
      r_tx       <= w_tx;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_baud_cnt = r_baud_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_char_cnt = r_char_cnt;
    w_len      = r_len;
    w_data     = r_data;
    w_shift    = r_shift;
    w_tx       = r_tx;
    w_busy     = r_busy;
    w_done     = 1'b0;

    if (r_state != ST_IDLE) begin
      w_baud_cnt = w_wrap ? '0 : r_baud_cnt + BCNT_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (ip_flag && (ip_len != '0)) begin
          w_state    = ST_START;
          w_busy     = 1'b1;
          w_tx       = 1'b0;
          w_data     = ip_data;
          w_shift    = ip_data[DATA_BITS-1:0];
          w_len      = w_len_clamp;
          w_char_cnt = '0;
          w_bit_cnt  = '0;
          w_baud_cnt = '0;
        end
      end
      ST_START: begin
        if (w_wrap) begin
          w_state   = ST_DATA;
          w_bit_cnt = '0;
          w_tx      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_bit_cnt = '0;
            if (PARITY != 0) begin
              w_state = ST_PARITY;
              w_tx    = w_par;
            end else begin
              w_state = ST_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + BIT_W'(1);
            w_shift   = r_shift >> 1;
            w_tx      = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_wrap) begin
          w_state   = ST_STOP;
          w_bit_cnt = '0;
          w_tx      = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            w_bit_cnt = '0;
            if (r_char_cnt == r_len - LEN_W'(1)) begin
              w_state = ST_IDLE;
              w_busy  = 1'b0;
              w_done  = 1'b1;
              w_tx    = 1'b1;
            end else begin
              // next start bit follows the stop bit with no idle gap
              w_state    = ST_START;
              w_char_cnt = r_char_cnt + LEN_W'(1);
              w_data     = w_data_nxt;
              w_shift    = w_data_nxt[DATA_BITS-1:0];
              w_tx       = 1'b0;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign tx   = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_uart_tx_frame                                             |
// | Purpose : scoreboard bench for uart_tx_frame (8N1 and 8E2 instances)   |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_uart_tx_frame;

  localparam int BDIV = 10;

  logic        clk;
  logic        rst_n;
  logic [63:0] ip_data0, ip_data1;
  logic [3:0]  ip_len0,  ip_len1;
  logic        ip_flag0, ip_flag1;
  logic        busy0, done0, tx0;
  logic        busy1, done1, tx1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cyc0 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int t_acc0, busy_base0, done_base0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  uart_tx_frame #(
    .CLK_FREQ(1000), .BAUD(100), .MAX_BYTES(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ip_data(ip_data0), .ip_len(ip_len0), .ip_flag(ip_flag0),
    .busy(busy0), .done(done0), .tx(tx0)
  );

  uart_tx_frame #(
    .CLK_FREQ(1000), .BAUD(100), .MAX_BYTES(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ip_data(ip_data1), .ip_len(ip_len1), .ip_flag(ip_flag1),
    .busy(busy1), .done(done1), .tx(tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy0) busy_cyc0 <= busy_cyc0 + 1;
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Receives one character whose start bit was seen at the current negedge
  task automatic rx_char(input bit which, input int npar, input int nstop);
    logic [7:0] got = '0;
    logic [7:0] exp;
    logic       par_bit = 1'b0;
    logic       stop_ok = 1'b1;
    logic       stable = 1'b1;
    logic       aborted = 1'b0;
    logic       v, first;
    int         nbits = 1 + 8 + npar + nstop;
    first = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int s = 0; s < BDIV; s++) begin
        if (s != 0 || b != 0) @(negedge clk);
        v = which ? tx1 : tx0;
        if (!rst_n) aborted = 1'b1;
        if (s == 0) first = v;
        else if (v !== first) stable = 1'b0;
      end
      if (b >= 1 && b <= 8) got[b-1] = first;
      else if (npar != 0 && b == 9) par_bit = first;
      else if (b > 0) stop_ok = stop_ok & (first === 1'b1);
    end
    if (!aborted) begin
      if ((which ? exp_q1.size() : exp_q0.size()) == 0) begin
        check(which ? "rx1_unexpected_char" : "rx0_unexpected_char", {24'd0, got}, 32'hFFFF_FFFF);
      end else begin
        exp = which ? exp_q1.pop_front() : exp_q0.pop_front();
        check(which ? "rx1_data" : "rx0_data", {24'd0, got}, {24'd0, exp});
        check(which ? "rx1_bit_timing" : "rx0_bit_timing", {31'd0, stable}, 32'd1);
        check(which ? "rx1_stop" : "rx0_stop", {31'd0, stop_ok}, 32'd1);
        if (npar != 0) check("rx1_parity_even", {31'd0, par_bit}, {31'd0, ^exp});
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx0 === 1'b0) rx_char(1'b0, 0, 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx1 === 1'b0) rx_char(1'b1, 1, 2);
    end
  end

  task automatic start0(input string tag, input logic [63:0] data, input logic [3:0] len, input int nexp);
    logic [63:0] d;
    d = data;
    @(negedge clk);
    ip_data0 = d; ip_len0 = len; ip_flag0 = 1'b1;
    busy_base0 = busy_cyc0;
    done_base0 = done_cnt0;
    for (int k = 0; k < nexp; k++) exp_q0.push_back(d[k*8 +: 8]);
    @(posedge clk);
    #1;
    t_acc0 = cyc;
    ip_flag0 = 1'b0; ip_data0 = ~d; ip_len0 = 4'd0;
    @(negedge clk);
    check({tag, "_latency_busy_tx"}, {30'd0, busy0, tx0}, 32'd2);
  endtask

  task automatic wait_done0(input string tag, input int exp_cycles);
    int n = 0;
    while (done0 !== 1'b1 && n < exp_cycles + 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_done_time"}, cyc - t_acc0, exp_cycles);
    check({tag, "_busy_cycles"}, busy_cyc0 - busy_base0, exp_cycles);
    check({tag, "_done_cycle_busy_tx"}, {30'd0, busy0, tx0}, 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done0}, 32'd0);
    check({tag, "_done_count"}, done_cnt0 - done_base0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int n;
    int base;
    rst_n = 1'b0;
    ip_data0 = '0; ip_len0 = '0; ip_flag0 = 1'b0;
    ip_data1 = '0; ip_len1 = '0; ip_flag1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dut0_tx_busy_done", {29'd0, tx0, busy0, done0}, 32'd4);
    check("reset_dut1_tx_busy_done", {29'd0, tx1, busy1, done1}, 32'd4);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single character A5
    start0("a5", 64'hA5, 4'd1, 1);
    wait_done0("a5", 100);

    // full eight-character frame
    start0("len8", 64'h0807060504030201, 4'd8, 8);
    wait_done0("len8", 800);

    // request while busy must not disturb latched data
    start0("midflag", 64'h55AA, 4'd2, 2);
    repeat (50) @(negedge clk);
    ip_data0 = 64'hDEAD_BEEF_1234_5678; ip_len0 = 4'd1; ip_flag0 = 1'b1;
    @(negedge clk);
    ip_flag0 = 1'b0;
    wait_done0("midflag", 200);

    // zero length is ignored
    @(negedge clk);
    base = done_cnt0;
    ip_data0 = 64'h77; ip_len0 = 4'd0; ip_flag0 = 1'b1;
    @(negedge clk);
    ip_flag0 = 1'b0;
    repeat (3) @(negedge clk);
    check("len0_busy_tx", {30'd0, busy0, tx0}, 32'd1);
    check("len0_no_done", done_cnt0 - base, 0);

    // length above MAX_BYTES clamps to eight characters
    start0("len12", 64'h1817161514131211, 4'd12, 8);
    wait_done0("len12", 800);

    // asynchronous reset inside character 3 data bits
    start0("rst", 64'h8877665544332211, 4'd8, 8);
    repeat (340) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx_busy", {30'd0, tx0, busy0}, 32'd2);
    exp_q0.delete();
    repeat (150) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_done", done_cnt0 - done_base0, 0);
    start0("after_rst", 64'h3C, 4'd1, 1);
    wait_done0("after_rst", 100);

    // flag held high: back-to-back frames with one idle clock
    @(negedge clk);
    base = done_cnt0;
    ip_data0 = 64'h5A; ip_len0 = 4'd1; ip_flag0 = 1'b1;
    for (int k = 0; k < 3; k++) exp_q0.push_back(8'h5A);
    @(posedge clk);
    #1;
    t = cyc;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (done0 !== 1'b1 && n < 150) begin
        n++;
        @(negedge clk);
      end
      check("b2b_period", cyc - t, 100);
      check("b2b_idle_tx", {31'd0, tx0}, 32'd1);
      if (f < 2) begin
        @(posedge clk);
        #1;
        t = cyc;
        if (f == 1) ip_flag0 = 1'b0;
        @(negedge clk);
        check("b2b_restart_busy_tx", {30'd0, busy0, tx0}, 32'd2);
      end
    end
    repeat (3) @(negedge clk);
    check("b2b_idle_after", {31'd0, busy0}, 32'd0);
    check("b2b_done_count", done_cnt0 - base, 3);

    // even parity, two stop bits
    @(negedge clk);
    base = done_cnt1;
    ip_data1 = 64'h0307; ip_len1 = 4'd2; ip_flag1 = 1'b1;
    exp_q1.push_back(8'h07);
    exp_q1.push_back(8'h03);
    @(posedge clk);
    #1;
    t = cyc;
    ip_flag1 = 1'b0; ip_data1 = '1;
    @(negedge clk);
    check("par_latency_busy_tx", {30'd0, busy1, tx1}, 32'd2);
    n = 0;
    while (done1 !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("par_frame_time", cyc - t, 240);
    @(negedge clk);
    check("par_done_count", done_cnt1 - base, 1);

    repeat (20) @(negedge clk);
    check("scoreboard0_empty", exp_q0.size(), 0);
    check("scoreboard1_empty", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
